avalon_inst_ram: RTL and testbench



---
 rtl/avalon_inst_ram.sv | 92 +++++++++
 tb/tb_avalon_inst_ram.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/avalon_inst_ram.sv
// Word-organised 32-bit Avalon-MM slave memory with byte-lane writes, a one-wait-state
// read handshake and a level-sensitive side-band preload port for program words.
module avalon_inst_ram #(
    parameter int ADDR_BITS = 8
) (
    input  logic        clk,
    input  logic        RAM_Reset,
    input  logic [31:0] address,
    input  logic        read,
    input  logic        write,
    input  logic [31:0] writedata,
    input  logic [3:0]  byteenable,
    output logic [31:0] readdata,
    output logic        waitrequest,
    input  logic [31:0] instruction,
    input  logic        inst_input,
    input  logic [7:0]  inst_addr
);
    localparam int IDX_W = ADDR_BITS - 2;
    localparam int DEPTH = 1 << IDX_W;

    // Two backing arrays: clocked bus/reset contents and latched preload contents.
    // Per word, the preload copy is current while pre_gen matches bus_gen; any bus
    // write or reset drives bus_gen to the opposite of pre_gen, handing the word back.
    logic [31:0]      bus_mem [DEPTH];
    logic [31:0]      pre_mem [DEPTH];
    logic [DEPTH-1:0] bus_gen;
    logic [DEPTH-1:0] pre_gen;

    logic [IDX_W-1:0] bus_idx;
    logic [IDX_W-1:0] pre_idx;
    logic [31:0]      cur_word;
    logic [31:0]      merged_word;
    logic             rd_done;
    logic             rd_fire;
    logic             wr_fire;
    logic             unused_bits;

    // Handshake: read is held by the master until waitrequest is low; a read is
    // captured on the first edge it is seen idle, the following edge re-arms it.
    // A simultaneous write takes the cycle and the read is dropped without stalling.
    assign bus_idx     = address[ADDR_BITS-1:2];
    assign pre_idx     = inst_addr[ADDR_BITS-1:2];
    assign waitrequest = read & ~write & ~rd_done;
    assign rd_fire     = read & ~write & ~rd_done;
    assign wr_fire     = write & (byteenable != 4'b0000);
    assign unused_bits = ^{address, inst_addr};

    assign cur_word = (pre_gen[bus_idx] == bus_gen[bus_idx]) ? pre_mem[bus_idx]
                                                             : bus_mem[bus_idx];

    always_comb begin
        merged_word = cur_word;
        for (int b = 0; b < 4; b++) begin
            if (byteenable[b]) begin
                merged_word[8*b +: 8] = writedata[8*b +: 8];
            end
        end
    end

    // Preload is transparent while enabled, so it also overrides a same-cycle bus
    // write or a reset on the same word once the clock edge has passed.
    always_latch begin
        if (inst_input) begin
            pre_mem[pre_idx] <= instruction;
            pre_gen[pre_idx] <= bus_gen[pre_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (RAM_Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                bus_mem[i] <= '0;
            end
            bus_gen  <= ~pre_gen;
            readdata <= '0;
            rd_done  <= 1'b0;
        end else begin
            if (wr_fire) begin
                bus_mem[bus_idx] <= merged_word;
                bus_gen[bus_idx] <= ~pre_gen[bus_idx];
            end
            if (rd_fire) begin
                readdata <= cur_word;
                rd_done  <= 1'b1;
            end else begin
                rd_done  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_avalon_inst_ram.sv
// Self-checking bench for avalon_inst_ram: directed test-plan scenarios with literal
// expectations plus randomized bus/preload traffic checked every cycle against a model.
module tb_avalon_inst_ram;
    logic        clk;
    logic        RAM_Reset;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
    logic [31:0] readdata;
    logic        waitrequest;
    logic [31:0] instruction;
    logic        inst_input;
    logic [7:0]  inst_addr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;

    logic [31:0] exp_q[$];

    // Behavioural model: plain word array, last returned word, and whether the
    // previous edge delivered a read.
    logic [31:0] m_mem [64];
    logic [31:0] m_rdata = 32'h0;
    bit          m_done = 0;

    avalon_inst_ram #(.ADDR_BITS(8)) dut (
        .clk         (clk),
        .RAM_Reset   (RAM_Reset),
        .address     (address),
        .read        (read),
        .write       (write),
        .writedata   (writedata),
        .byteenable  (byteenable),
        .readdata    (readdata),
        .waitrequest (waitrequest),
        .instruction (instruction),
        .inst_input  (inst_input),
        .inst_addr   (inst_addr)
    );

    // clock / reset block
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // model
    always @(inst_input or inst_addr or instruction) begin
        if (inst_input) m_mem[inst_addr[7:2]] = instruction;
    end

    always @(posedge clk) begin
        if (RAM_Reset) begin
            for (int i = 0; i < 64; i++) m_mem[i] = 32'h0;
            m_rdata = 32'h0;
            m_done  = 0;
        end else begin
            if (write) begin
                for (int b = 0; b < 4; b++)
                    if (byteenable[b]) m_mem[address[7:2]][8*b +: 8] = writedata[8*b +: 8];
            end
            if (read && !write && !m_done) begin
                m_rdata = m_mem[address[7:2]];
                m_done  = 1;
            end else begin
                m_done  = 0;
            end
        end
    end

    // compare process
    always @(negedge clk) begin
        if (chk_en) begin
            check("waitrequest", 32'(waitrequest), 32'(read & ~write & ~m_done));
            check("readdata", readdata, m_rdata);
        end
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        inst_addr = a;
        #1 instruction = d;
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
        address = a; writedata = d; byteenable = be; write = 1;
        step();
        write = 0;
    endtask

    task automatic do_read(input logic [31:0] a, input string name);
        logic        first_wait;
        int          n;
        logic [31:0] exp;
        address = a; read = 1;
        @(negedge clk);
        first_wait = waitrequest;
        n = 0;
        while (waitrequest && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n == 8) check({name, "_timeout"}, 32'(waitrequest), 32'h0);
        check({name, "_first_wait"}, 32'(first_wait), 32'h1);
        check({name, "_latency"}, 32'(n), 32'h1);
        if (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check(name, readdata, exp);
        end
        step();
        read = 0;
    endtask

    initial begin
        logic [3:0] pat;
        RAM_Reset = 1; address = 0; read = 0; write = 0; writedata = 0; byteenable = 0;
        instruction = 0; inst_input = 0; inst_addr = 0;
        step();
        RAM_Reset = 0;
        chk_en = 1;
        @(negedge clk);
        check("reset_readdata", readdata, 32'h0);
        check("reset_wait", 32'(waitrequest), 32'h0);
        step();

        // preload three words between two edges
        inst_input = 1;
        preload(8'h04, 32'h24032468);
        preload(8'h08, 32'h3062FFFF);
        preload(8'h0C, 32'h00000008);
        inst_input = 0;
        step();
        exp_q.push_back(32'h24032468); do_read(32'h04, "rd_04");
        exp_q.push_back(32'h3062FFFF); do_read(32'h08, "rd_08");
        exp_q.push_back(32'h00000008); do_read(32'h0C, "rd_0c");
        exp_q.push_back(32'h3062FFFF); do_read(32'hBFC00008, "rd_alias");

        // byte-lane writes
        do_write(32'h10, 32'hAABBCCDD, 4'b1111);
        do_write(32'h10, 32'h11223344, 4'b0011);
        exp_q.push_back(32'hAABB3344); do_read(32'h10, "rd_lanes");
        do_write(32'h10, 32'hFFFFFFFF, 4'b0000);
        exp_q.push_back(32'hAABB3344); do_read(32'h10, "rd_be0");
        do_write(32'h14, 32'hEE000000, 4'b1000);
        exp_q.push_back(32'hEE000000); do_read(32'h14, "rd_lane3");

        // read held for four cycles
        pat = 4'b1010;
        address = 32'h04; read = 1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("hold_wait", 32'(waitrequest), 32'(pat[3-k]));
            if (!pat[3-k]) check("hold_data", readdata, 32'h24032468);
        end
        step();
        read = 0;

        // partial write over a preloaded word
        do_write(32'h04, 32'hEE000000, 4'b1000);
        exp_q.push_back(32'hEE032468); do_read(32'h04, "rd_pre_merge");

        // read and write together
        address = 32'h20; writedata = 32'h12345678; byteenable = 4'b1111; read = 1; write = 1;
        @(negedge clk);
        check("rw_wait", 32'(waitrequest), 32'h0);
        step();
        read = 0; write = 0;
        exp_q.push_back(32'h12345678); do_read(32'h20, "rd_rw");

        // reset during a pending read
        address = 32'h08; read = 1; RAM_Reset = 1;
        @(negedge clk);
        check("mid_wait0", 32'(waitrequest), 32'h1);
        check("mid_hold", readdata, 32'h12345678);
        step();
        RAM_Reset = 0;
        @(negedge clk);
        check("mid_restall", 32'(waitrequest), 32'h1);
        check("mid_cleared", readdata, 32'h0);
        @(negedge clk);
        check("mid_done_wait", 32'(waitrequest), 32'h0);
        check("mid_done_data", readdata, 32'h0);
        step();
        read = 0;
        for (int w = 0; w < 64; w++) begin
            exp_q.push_back(32'h0);
            do_read(32'(w * 4), "rd_zero");
        end

        // randomized traffic
        for (int c = 0; c < 500; c++) begin
            address    = $urandom;
            writedata  = $urandom;
            byteenable = 4'($urandom_range(0, 15));
            read       = ($urandom_range(0, 99) < 60);
            write      = ($urandom_range(0, 99) < 30);
            RAM_Reset  = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 99) < 15) begin
                inst_input = 1;
                preload(8'($urandom), $urandom);
                inst_input = 0;
            end
            step();
        end
        read = 0; write = 0; RAM_Reset = 0;
        step();
        step();
        chk_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
